// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - pipeline-side signal bundle for the multi-cycle mul/div unit
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hilo_rd;
   logic             flush;
   logic             busy;
   logic             done;
   logic             stall;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, a, b, hilo_rd, flush,
      input  busy, done, stall, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, a, b, hilo_rd, flush,
      output busy, done, stall, hi, lo, div_by_zero
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - HI/LO owner sequencing a shift-add multiplier and restoring divider
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input logic               clk,
   input logic               rst,
   muldiv_sequencer_if.slave mdu
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_MTHI  = 2'b10;
   localparam logic [1:0] OP_MTLO  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t             state, state_nx;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_inc;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               dbz_q;
   logic               accept, last;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nx;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   rem_nx;
   logic [WIDTH-1:0]   quo_nx;

   // acc holds {partial product, multiplier} for MUL; its low half is the dividend/quotient for DIV
   always_comb begin
      cnt_inc   = cnt + CW'(1);
      last      = (cnt_inc == CW'(WIDTH));
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      mul_nx    = {mul_sum, acc[WIDTH-1:1]};
      div_shift = {rem, acc[WIDTH-1]};
      div_ok    = (div_shift >= {1'b0, opnd});
      div_diff  = div_shift[WIDTH-1:0] - opnd;
      rem_nx    = div_ok ? div_diff : div_shift[WIDTH-1:0];
      quo_nx    = {acc[WIDTH-2:0], div_ok};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      accept     = 1'b0;
      mdu.busy   = 1'b0;
      mdu.done   = 1'b0;
      mdu.stall  = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            mdu.done = (state == S_DONE);
            accept   = mdu.start & ~mdu.flush;
            state_nx = S_IDLE;
            if (accept && mdu.op == OP_MULTU) state_nx = S_MUL;
            if (accept && mdu.op == OP_DIVU)  state_nx = S_DIV;
         end
         S_MUL, S_DIV: begin
            mdu.busy  = 1'b1;
            mdu.stall = mdu.start | mdu.hilo_rd;
            if (mdu.flush)  state_nx = S_IDLE;
            else if (last)  state_nx = S_DONE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         acc   <= '0;
         opnd  <= '0;
         rem   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         dbz_q <= 1'b0;
      end else if (accept) begin
         case (mdu.op)
            OP_MULTU: begin
               acc   <= {{WIDTH{1'b0}}, mdu.b};
               opnd  <= mdu.a;
               cnt   <= '0;
               dbz_q <= 1'b0;
            end
            OP_DIVU: begin
               acc   <= {{WIDTH{1'b0}}, mdu.a};
               opnd  <= mdu.b;
               rem   <= '0;
               cnt   <= '0;
               dbz_q <= 1'b0;
            end
            OP_MTHI: hi_q <= mdu.a;
            OP_MTLO: lo_q <= mdu.a;
            default: ;
         endcase
      end else if (state == S_MUL && !mdu.flush) begin
         acc <= mul_nx;
         cnt <= cnt_inc;
         if (last) begin
            hi_q <= mul_nx[2*WIDTH-1:WIDTH];
            lo_q <= mul_nx[WIDTH-1:0];
         end
      end else if (state == S_DIV && !mdu.flush) begin
         acc[WIDTH-1:0] <= quo_nx;
         rem            <= rem_nx;
         cnt            <= cnt_inc;
         // a zero divisor never fails the compare, giving all-ones quotient and remainder = dividend
         if (last) begin
            hi_q  <= rem_nx;
            lo_q  <= quo_nx;
            dbz_q <= (opnd == '0);
         end
      end
   end

   assign mdu.hi          = hi_q;
   assign mdu.lo          = lo_q;
   assign mdu.div_by_zero = dbz_q;
endmodule
